// File: rtl/msg_schedule_gen.sv
// rtl/msg_schedule_gen.sv - SHA-256 message schedule generator
// Emits W[0..63] with K[t] from a 16-word sliding window, one word per accepted handshake.
module msg_schedule_gen #(
  parameter int DATA_WID = 32,
  parameter int WORD_NUM = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_NUM*DATA_WID-1:0] iv_blk_data,
  input  logic                         i_blk_vld,
  output logic                         o_blk_rdy,
  output logic [DATA_WID-1:0]          ov_w_data,
  output logic [DATA_WID-1:0]          ov_k_data,
  output logic                         o_w_data_vld,
  input  logic                         i_w_rdy,
  output logic [5:0]                   ov_round_idx,
  output logic                         o_last
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t              state_q, state_d;
  logic [DATA_WID-1:0] win_q [WORD_NUM];
  logic [5:0]          t_q;
  logic                blk_acc, w_acc;
  logic [DATA_WID-1:0] new_w;

  function automatic logic [DATA_WID-1:0] rotr(input logic [DATA_WID-1:0] x, input int n);
    return (x >> n) | (x << (DATA_WID - n));
  endfunction

  function automatic logic [DATA_WID-1:0] ssig0(input logic [DATA_WID-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_WID-1:0] ssig1(input logic [DATA_WID-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Slot 0 holds W[t], so W[t+16] draws on slots 14, 9, 1 and 0.
  assign new_w = ssig1(win_q[WORD_NUM-2]) + win_q[WORD_NUM-7] + ssig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d      = state_q;
    o_blk_rdy    = 1'b0;
    o_w_data_vld = 1'b0;
    blk_acc      = 1'b0;
    w_acc        = 1'b0;
    case (state_q)
      IDLE: begin
        o_blk_rdy = 1'b1;
        blk_acc   = i_blk_vld;
        if (i_blk_vld) state_d = RUN;
      end
      RUN: begin
        o_w_data_vld = 1'b1;
        w_acc        = i_w_rdy;
        if (i_w_rdy && t_q == 6'd63) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WORD_NUM; k++) win_q[k] <= '0;
      t_q <= '0;
    end else if (blk_acc) begin
      for (int j = 0; j < WORD_NUM; j++) win_q[j] <= iv_blk_data[DATA_WID*j +: DATA_WID];
      t_q <= '0;
    end else if (w_acc) begin
      for (int k = 0; k < WORD_NUM-1; k++) win_q[k] <= win_q[k+1];
      win_q[WORD_NUM-1] <= new_w;
      t_q <= t_q + 6'd1;
    end
  end

  assign ov_w_data    = win_q[0];
  assign ov_k_data    = K_ROM[t_q];
  assign ov_round_idx = t_q;
  assign o_last       = (state_q == RUN) && (t_q == 6'd63);

endmodule

// File: tb/tb_msg_schedule_gen.sv
// tb/tb_msg_schedule_gen.sv - scoreboard bench for msg_schedule_gen
// Expected words come from the plain W[t] recurrence over a 64-entry array.
module tb_msg_schedule_gen;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] iv_blk_data = '0;
  logic         i_blk_vld = 1'b0;
  logic         o_blk_rdy;
  logic [31:0]  ov_w_data, ov_k_data;
  logic         o_w_data_vld;
  logic         i_w_rdy = 1'b0;
  logic [5:0]   ov_round_idx;
  logic         o_last;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];
  logic [511:0] abc_blk;

  msg_schedule_gen dut (
    .clk(clk), .rst_n(rst_n), .iv_blk_data(iv_blk_data), .i_blk_vld(i_blk_vld),
    .o_blk_rdy(o_blk_rdy), .ov_w_data(ov_w_data), .ov_k_data(ov_k_data),
    .o_w_data_vld(o_w_data_vld), .i_w_rdy(i_w_rdy), .ov_round_idx(ov_round_idx), .o_last(o_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference model: build the full 64-word schedule, push it to the scoreboard.
  task automatic push_model(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_t e;
    for (int j = 0; j < 16; j++) w[j] = blk[32*j +: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.w = w[t]; e.k = KT[t]; e.idx = 6'(t); e.last = (t == 63);
      sb.push_back(e);
    end
  endtask

  // Monitor: pop on each handshake, and hold-check every stalled cycle.
  logic        stall_prev = 1'b0;
  logic [31:0] pw, pk;
  logic [5:0]  pidx;
  logic        plast;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_w", ov_w_data, pw);
        check("stall_hold_k", ov_k_data, pk);
        check("stall_hold_idx", {26'd0, ov_round_idx}, {26'd0, pidx});
        check("stall_hold_vld", {31'd0, o_w_data_vld}, 32'd1);
        check("stall_hold_last", {31'd0, o_last}, {31'd0, plast});
      end
      if (o_w_data_vld && i_w_rdy) begin
        if (sb.size() == 0) begin
          check("extra_word", {26'd0, ov_round_idx}, 32'hffffffff);
        end else begin
          e = sb.pop_front();
          check("w_data", ov_w_data, e.w);
          check("k_data", ov_k_data, e.k);
          check("round_idx", {26'd0, ov_round_idx}, {26'd0, e.idx});
          check("last", {31'd0, o_last}, {31'd0, e.last});
          cap_w[ov_round_idx] = ov_w_data;
          cap_k[ov_round_idx] = ov_k_data;
        end
      end
      if (!o_w_data_vld && o_last) check("last_without_vld", 32'd1, 32'd0);
      stall_prev = o_w_data_vld && !i_w_rdy;
      pw = ov_w_data; pk = ov_k_data; pidx = ov_round_idx; plast = o_last;
    end
  end

  task automatic send_block(input logic [511:0] blk);
    int c = 0;
    while (!o_blk_rdy && c < 200) begin
      @(posedge clk); #1; c++;
    end
    check("blk_rdy_before_send", {31'd0, o_blk_rdy}, 32'd1);
    push_model(blk);
    iv_blk_data = blk;
    i_blk_vld   = 1'b1;
    i_w_rdy     = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    i_blk_vld   = 1'b0;
    iv_blk_data = {16{$urandom}};
    check("latency_vld", {31'd0, o_w_data_vld}, 32'd1);
    check("latency_idx", {26'd0, ov_round_idx}, 32'd0);
    check("blk_rdy_in_run", {31'd0, o_blk_rdy}, 32'd0);
  endtask

  task automatic run_words(input bit stall, input bit pulse10, input bit rst20);
    int cyc = 0;
    int acc = 0;
    while (sb.size() > 0 && cyc < 2000) begin
      i_w_rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pulse10 && o_w_data_vld && ov_round_idx == 6'd10) begin
        i_blk_vld   = 1'b1;
        iv_blk_data = {16{$urandom}};
        check("blk_rdy_during_pulse", {31'd0, o_blk_rdy}, 32'd0);
      end else begin
        i_blk_vld = 1'b0;
      end
      if (rst20 && o_w_data_vld && ov_round_idx == 6'd20) begin
        rst_n = 1'b0;
        #1;
        check("async_rst_vld", {31'd0, o_w_data_vld}, 32'd0);
        check("async_rst_blk_rdy", {31'd0, o_blk_rdy}, 32'd1);
        check("async_rst_last", {31'd0, o_last}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        check("rst_w_zero", ov_w_data, 32'd0);
        check("rst_k0", ov_k_data, KT[0]);
        check("rst_idx", {26'd0, ov_round_idx}, 32'd0);
        rst_n     = 1'b1;
        i_blk_vld = 1'b0;
        i_w_rdy   = 1'b0;
        return;
      end
      if (o_w_data_vld && i_w_rdy) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    i_w_rdy   = 1'b0;
    i_blk_vld = 1'b0;
    check("scoreboard_drained", sb.size(), 32'd0);
    check("words_accepted", acc, 32'd64);
    if (!stall) check("cycles_to_idle", cyc, 32'd64);
    check("idle_vld", {31'd0, o_w_data_vld}, 32'd0);
    check("idle_blk_rdy", {31'd0, o_blk_rdy}, 32'd1);
  endtask

  initial begin
    abc_blk = '0;
    abc_blk[31:0]    = 32'h61626380;
    abc_blk[511:480] = 32'h00000018;

    repeat (3) @(posedge clk);
    #1;
    check("reset_blk_rdy", {31'd0, o_blk_rdy}, 32'd1);
    check("reset_vld", {31'd0, o_w_data_vld}, 32'd0);
    check("reset_last", {31'd0, o_last}, 32'd0);
    check("reset_w", ov_w_data, 32'd0);
    check("reset_k", ov_k_data, KT[0]);
    check("reset_idx", {26'd0, ov_round_idx}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 64; t++) begin cap_w[t] = 32'hdeadbeef; cap_k[t] = 32'hdeadbeef; end
    send_block(abc_blk);
    run_words(1'b0, 1'b0, 1'b0);
    check("abc_w0", cap_w[0], 32'h61626380);
    check("abc_w15", cap_w[15], 32'h00000018);
    check("abc_w16", cap_w[16], 32'h61626380);
    check("abc_w17", cap_w[17], 32'h000f0000);
    check("abc_w18", cap_w[18], 32'h7da86405);
    check("abc_k0", cap_k[0], 32'h428a2f98);
    check("abc_k63", cap_k[63], 32'hc67178f2);

    send_block('0);
    run_words(1'b0, 1'b0, 1'b0);

    send_block(abc_blk);
    run_words(1'b1, 1'b0, 1'b0);

    send_block(abc_blk);
    run_words(1'b0, 1'b1, 1'b0);

    send_block({16{$urandom}});
    run_words(1'b1, 1'b0, 1'b1);
    send_block({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    run_words(1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      send_block({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      run_words(n[0], 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msg_schedule_gen.md
MSG_SCHEDULE_GEN -- requirements
Module: msg_schedule_gen

Interface
REQ-001 SHALL have parameter DATA_WID, default 32, word width in bits.
REQ-002 SHALL have parameter WORD_NUM, default 16, words per message block.
REQ-003 SHALL have port clk  input  1  module clock; all logic in this single clock domain.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port iv_blk_data  input  WORD_NUM*DATA_WID  512-bit message block; word j = iv_blk_data[DATA_WID*j +: DATA_WID].
REQ-006 SHALL have port i_blk_vld  input  1  block valid.
REQ-007 SHALL have port o_blk_rdy  output  1  block accepted when i_blk_vld & o_blk_rdy.
REQ-008 SHALL have port ov_w_data  output  DATA_WID  expanded message word W[t].
REQ-009 SHALL have port ov_k_data  output  DATA_WID  round constant K[t].
REQ-010 SHALL have port o_w_data_vld  output  1  W/K valid.
REQ-011 SHALL have port i_w_rdy  input  1  downstream accepts word when o_w_data_vld & i_w_rdy.
REQ-012 SHALL have port ov_round_idx  output  6  current t, 0..63.
REQ-013 SHALL have port o_last  output  1  high with o_w_data_vld when t = 63.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, RUN.
REQ-015 IDLE: o_blk_rdy = 1, o_w_data_vld = 0; on i_blk_vld load the 16-word window with W[0..15] = block words 0..15, set t = 0, go to RUN.
REQ-016 RUN: o_blk_rdy = 0, o_w_data_vld = 1; i_blk_vld is ignored and no block is captured.
REQ-017 Latency: W[0] SHALL be valid on the first clock edge after the block-accept edge.
REQ-018 On each accepted word, the window SHALL shift one position (slot k <= slot k+1), slot 15 <= new word, and t SHALL increment.
REQ-019 New word SHALL be ssig1(W[t-2]) + W[t-7] + ssig0(W[t-15]) + W[t-16] mod 2^32, computed from the current window.
REQ-020 ssig0(x) SHALL be ROTR7 ^ ROTR18 ^ SHR3; ssig1(x) SHALL be ROTR17 ^ ROTR19 ^ SHR10.
REQ-021 W[0..15] SHALL pass through unmodified; W[16..63] SHALL be produced per REQ-019.
REQ-022 ov_k_data SHALL be K[t] from the 64-entry FIPS 180-4 SHA-256 constant ROM indexed by registered t.
REQ-023 ov_w_data, ov_round_idx, o_w_data_vld and o_last SHALL be driven only from registers or from the ROM; no combinational path from any input.
REQ-024 Backpressure: while o_w_data_vld = 1 and i_w_rdy = 0, all outputs and the window SHALL hold unchanged for any number of cycles.
REQ-025 On acceptance at t = 63, the FSM SHALL return to IDLE and o_w_data_vld SHALL fall on the next edge; t SHALL reset to 0 with no wrap to a 65th word.
REQ-026 Throughput: at most one block per 65 cycles with i_w_rdy held high (1 load cycle + 64 words).
REQ-027 i_w_rdy while o_w_data_vld = 0 SHALL have no effect.

Reset
REQ-028 rst_n = 0 SHALL asynchronously force IDLE, t = 0, window = 0, o_w_data_vld = 0, o_last = 0, o_blk_rdy = 1, ov_w_data = 0, ov_k_data = K[0].
REQ-029 Reset asserted mid-RUN SHALL abort the block with no further words emitted; after release, a new block SHALL be accepted normally.

Verification
REQ-030 Padded "abc" block (word0 = 0x61626380, word15 = 0x00000018, others 0), i_w_rdy = 1 -> W[0] = 0x61626380, W[15] = 0x00000018, W[16] = 0x61626380, W[17] = 0x000F0000, W[18] = 0x7DA86405; K[0] = 0x428A2F98, K[63] = 0xC67178F2; o_last only at t = 63; exactly 64 valid words.
REQ-031 All-zero block -> all 64 W words = 0x00000000; K sequence matches the ROM; back in IDLE 65 cycles after accept.
REQ-032 Random i_w_rdy stalls on the "abc" block -> word sequence identical to REQ-030; outputs stable during every stall cycle.
REQ-033 i_blk_vld pulsed with a different block at t = 10 -> ignored; output sequence unchanged; o_blk_rdy stays 0 until IDLE.
REQ-034 rst_n pulsed low at t = 20 -> o_w_data_vld = 0 immediately (asynchronously); o_blk_rdy = 1 after release; next block produces a correct W[0].
